// File: rtl/ro_sensor_bank_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ro_sensor_bank_if : measurement request / result bundle for ro_sensor_bank
// Rev 1.0
// ---------------------------------------------------------------------------
interface ro_sensor_bank_if #(
  parameter int NUM_RO = 4,
  parameter int CNT_W  = 24,
  parameter int WIN_W  = 20
);
  localparam int SEL_W = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;

  logic              start;
  logic              scan;
  logic [SEL_W-1:0]  sel;
  logic [WIN_W-1:0]  window;
  logic              busy;
  logic              valid;
  logic [SEL_W-1:0]  ch;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [NUM_RO-1:0] ro_out;

  modport master (
    output start, scan, sel, window,
    input  busy, valid, ch, count, ovf, ro_out
  );

  modport slave (
    input  start, scan, sel, window,
    output busy, valid, ch, count, ovf, ro_out
  );
endinterface
`default_nettype wire

// File: rtl/ro_sensor_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ro_sensor_bank : bank of ring oscillators with a gated synchronous edge counter
// Rev 1.0
// ---------------------------------------------------------------------------
module ro_sensor_bank #(
  parameter int                  NUM_RO   = 4,
  parameter int                  STAGES   = 31,
  parameter int                  CNT_W    = 24,
  parameter int                  WIN_W    = 20,
  parameter int                  SETTLE   = 16,
  // All-zero builds real inverter rings; otherwise byte k is the half period
  // (in clk cycles) of a clocked stand-in for ring k.
  parameter logic [8*NUM_RO-1:0] SIM_HALF = '0
) (
  input wire               clk,
  input wire               rst,
  ro_sensor_bank_if.slave  bus
);
  localparam int                SEL_W       = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
  localparam logic [WIN_W-1:0]  SETTLE_LAST = WIN_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0]  LAST_CH     = SEL_W'(NUM_RO - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              scan_q, scan_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              acc_ovf_q, acc_ovf_d;
  logic [NUM_RO-1:0] en_q, en_d;
  logic [2:0]        sync_q, sync_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [NUM_RO-1:0] ro_raw;
  logic              ro_sel;
  logic              ro_rise;
  logic [SEL_W-1:0]  sel_clamped;

  for (genvar k = 0; k < NUM_RO; k++) begin : g_ro
    if (SIM_HALF == '0) begin : g_inv_ring
      (* dont_touch = "true" *) wire [STAGES-1:0] node;
      wire fb;

      // Disabled ring sees a constant 0 and rests at a static level.
      assign fb      = en_q[k] ? node[STAGES-1] : 1'b0;
      assign node[0] = ~fb;
      for (genvar s = 1; s < STAGES; s++) begin : g_stage
        assign node[s] = ~node[s-1];
      end
      assign ro_raw[k] = node[STAGES-1];
    end else begin : g_model
      localparam logic [7:0] HALF = SIM_HALF[8*k +: 8];
      localparam logic       REST = ((STAGES % 2) == 1);
      logic [7:0] div_q, div_d;
      logic       lvl_q, lvl_d;

      always_comb begin
        div_d = div_q + 8'd1;
        lvl_d = lvl_q;
        if (!en_q[k]) begin
          div_d = '0;
          lvl_d = REST;
        end else if (div_q == HALF - 8'd1) begin
          div_d = '0;
          lvl_d = ~lvl_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          div_q <= '0;
          lvl_q <= REST;
        end else begin
          div_q <= div_d;
          lvl_q <= lvl_d;
        end
      end
      assign ro_raw[k] = lvl_q;
    end
  end

  assign ro_sel      = |(ro_raw & en_q);
  assign ro_rise     = sync_q[1] & ~sync_q[2];
  assign sel_clamped = (bus.sel > LAST_CH) ? LAST_CH : bus.sel;

  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    cur_ch_d  = cur_ch_q;
    win_d     = win_q;
    tmr_d     = tmr_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    ch_d      = ch_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    sync_d    = {sync_q[1:0], ro_sel};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          scan_d   = bus.scan;
          cur_ch_d = bus.scan ? '0 : sel_clamped;
          win_d    = (bus.window == '0) ? WIN_W'(1) : bus.window;
          tmr_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d     = '0;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          state_d   = S_MEASURE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_MEASURE: begin
        // ovf flags an edge that arrived after the counter was already full
        if (ro_rise) begin
          if (acc_q == CNT_MAX) acc_ovf_d = 1'b1;
          else                  acc_d     = acc_q + 1'b1;
        end
        if (tmr_q == win_q - 1'b1) begin
          tmr_d   = '0;
          state_d = S_REPORT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_REPORT: begin
        valid_d = 1'b1;
        ch_d    = cur_ch_q;
        count_d = acc_q;
        ovf_d   = acc_ovf_q;
        tmr_d   = '0;
        if (scan_q && (cur_ch_q != LAST_CH)) begin
          cur_ch_d = cur_ch_q + 1'b1;
          state_d  = S_SETTLE;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    en_d = '0;
    if ((state_d == S_SETTLE) || (state_d == S_MEASURE)) begin
      en_d = NUM_RO'(1) << cur_ch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      scan_q    <= 1'b0;
      cur_ch_q  <= '0;
      win_q     <= '0;
      tmr_q     <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      en_q      <= '0;
      sync_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      cur_ch_q  <= cur_ch_d;
      win_q     <= win_d;
      tmr_q     <= tmr_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      en_q      <= en_d;
      sync_q    <= sync_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.ch     = ch_q;
  assign bus.count  = count_q;
  assign bus.ovf    = ovf_q;
  assign bus.ro_out = ro_raw;
endmodule
`default_nettype wire

// File: tb/tb_ro_sensor_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ro_sensor_bank : scoreboard bench, main bank plus a narrow-counter bank
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ro_sensor_bank;
  localparam int SETTLE = 16;

  typedef struct {
    int ch;
    int lo;
    int hi;
    bit ovf;
    int cyc;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q_m[$];
  exp_t q_s[$];
  exp_t em, es;
  int   half_m[4] = '{4, 5, 6, 8};
  int   half_s[3] = '{8, 3, 2};
  logic [3:0] ro0;
  bit   changed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ro_sensor_bank_if #(.NUM_RO(4), .CNT_W(24), .WIN_W(20)) m_if ();
  ro_sensor_bank_if #(.NUM_RO(3), .CNT_W(4),  .WIN_W(20)) s_if ();

  ro_sensor_bank #(
    .NUM_RO(4), .STAGES(31), .CNT_W(24), .WIN_W(20), .SETTLE(SETTLE),
    .SIM_HALF({8'd8, 8'd6, 8'd5, 8'd4})
  ) u_main (.clk(clk), .rst(rst), .bus(m_if));

  ro_sensor_bank #(
    .NUM_RO(3), .STAGES(31), .CNT_W(4), .WIN_W(20), .SETTLE(SETTLE),
    .SIM_HALF({8'd2, 8'd3, 8'd8})
  ) u_sat (.clk(clk), .rst(rst), .bus(s_if));

  task automatic chk(input string name, input bit ok, input int act, input int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // A square wave of period P has floor or ceil(W/P) rising edges in any W cycles.
  function automatic void model(input int half, input int w, input int cntw,
                                output int lo, output int hi, output bit ov);
    int n, mx;
    n  = w / (2 * half);
    mx = (1 << cntw) - 1;
    lo = (n > 0) ? n - 1 : 0;
    hi = n + 1;
    ov = 1'b0;
    if (lo > mx) begin
      lo = mx;
      hi = mx;
      ov = 1'b1;
    end else if (hi > mx) begin
      hi = mx;
    end
  endfunction

  task automatic issue(input bit sat, input bit scan, input int sel, input int win);
    exp_t e;
    int   w, nch, ch0, lo, hi, c;
    bit   ov;
    w = (win == 0) ? 1 : win;
    @(negedge clk);
    c = cyc;
    if (sat) begin
      s_if.start = 1'b1; s_if.scan = scan; s_if.sel = 2'(sel); s_if.window = 20'(win);
      nch = scan ? 3 : 1;
      ch0 = scan ? 0 : ((sel > 2) ? 2 : sel);
    end else begin
      m_if.start = 1'b1; m_if.scan = scan; m_if.sel = 2'(sel); m_if.window = 20'(win);
      nch = scan ? 4 : 1;
      ch0 = scan ? 0 : sel;
    end
    for (int i = 0; i < nch; i++) begin
      model(sat ? half_s[ch0+i] : half_m[ch0+i], w, sat ? 4 : 24, lo, hi, ov);
      e.ch   = ch0 + i;
      e.lo   = lo;
      e.hi   = hi;
      e.ovf  = ov;
      e.cyc  = c + SETTLE + w + 2 + i * (SETTLE + w + 1);
      e.last = (i == nch - 1);
      if (sat) q_s.push_back(e);
      else     q_m.push_back(e);
    end
    @(negedge clk);
    if (sat) s_if.start = 1'b0;
    else     m_if.start = 1'b0;
  endtask

  task automatic wait_done(input bit sat, input int budget);
    int n = 0;
    while ((sat ? (s_if.busy || q_s.size() != 0) : (m_if.busy || q_m.size() != 0))
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(sat ? "sat_done_timeout" : "main_done_timeout", n < budget, n, budget);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_item(input string p, input exp_t e, input int ch, input int cnt,
                            input bit ov, input bit busy);
    chk({p, "_ch"},      ch == e.ch, ch, e.ch);
    chk({p, "_count"},   (cnt >= e.lo) && (cnt <= e.hi), cnt, (e.lo + e.hi) / 2);
    chk({p, "_ovf"},     ov == e.ovf, int'(ov), int'(e.ovf));
    chk({p, "_latency"}, cyc == e.cyc, cyc, e.cyc);
    chk({p, "_busy"},    busy == !e.last, int'(busy), int'(!e.last));
  endtask

  always @(negedge clk) begin
    if (!rst && m_if.valid) begin
      if (q_m.size() == 0) chk("main_unexpected_valid", 1'b0, 1, 0);
      else begin
        em = q_m.pop_front();
        check_item("main", em, int'(m_if.ch), int'(m_if.count), m_if.ovf, m_if.busy);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_if.valid) begin
      if (q_s.size() == 0) chk("sat_unexpected_valid", 1'b0, 1, 0);
      else begin
        es = q_s.pop_front();
        check_item("sat", es, int'(s_if.ch), int'(s_if.count), s_if.ovf, s_if.busy);
      end
    end
  end

  initial begin
    m_if.start = 1'b0; m_if.scan = 1'b0; m_if.sel = '0; m_if.window = '0;
    s_if.start = 1'b0; s_if.scan = 1'b0; s_if.sel = '0; s_if.window = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",  m_if.busy == 1'b0,  int'(m_if.busy),  0);
    chk("rst_valid", m_if.valid == 1'b0, int'(m_if.valid), 0);
    chk("rst_ch",    m_if.ch == '0,      int'(m_if.ch),    0);
    chk("rst_count", m_if.count == '0,   int'(m_if.count), 0);
    chk("rst_ovf",   m_if.ovf == 1'b0,   int'(m_if.ovf),   0);
    chk("rst_sat_busy", s_if.busy == 1'b0, int'(s_if.busy), 0);
    ro0 = m_if.ro_out;
    changed = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (m_if.ro_out != ro0) changed = 1'b1;
    end
    chk("ro_out_static", !changed, int'(changed), 0);

    issue(0, 0, 2, 1000); wait_done(0, 3000);
    issue(0, 1, 3, 480);  wait_done(0, 3000);
    issue(0, 0, 1, 0);    wait_done(0, 200);
    for (int i = 0; i < 6; i++) begin
      issue(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(20, 600));
      wait_done(0, 3000);
    end

    // start while busy must leave the running measurement untouched
    issue(0, 0, 1, 300);
    repeat (60) @(negedge clk);
    m_if.start = 1'b1; m_if.scan = 1'b1; m_if.sel = 2'd3; m_if.window = 20'd5;
    @(negedge clk);
    m_if.start = 1'b0;
    chk("busy_hold", m_if.busy == 1'b1, int'(m_if.busy), 1);
    wait_done(0, 3000);

    // reset in the middle of MEASURE aborts without a result
    m_if.start = 1'b1; m_if.scan = 1'b0; m_if.sel = 2'd1; m_if.window = 20'd500;
    @(negedge clk);
    m_if.start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  m_if.busy == 1'b0,  int'(m_if.busy),  0);
    chk("abort_valid", m_if.valid == 1'b0, int'(m_if.valid), 0);
    repeat (600) @(negedge clk);
    issue(0, 0, 3, 100); wait_done(0, 1000);

    issue(1, 0, 3, 200); wait_done(1, 1000);
    issue(1, 0, 0, 200); wait_done(1, 1000);
    issue(1, 1, 0, 40);  wait_done(1, 1000);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
